instruction_fetch_unit: RTL and testbench

- Fetch stage directly downstream of the instruction address generator.
- Latches the current PC and issues a read request to instruction memory over a req/ack handshake. Captures the returned word into an instruction register (IR) and presents it to decode under a valid/ready handshake.
- Pulses PC_enable for one cycle per accepted fetch so the address generator advances.
- Supports a flush for branch/jump redirects and a memory-timeout error.

---
 rtl/instruction_fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage sitting directly behind the instruction address generator.
// Latches the incoming PC, issues a read to instruction memory over a
// Mem_Req/Mem_Ack handshake, captures the returned word into the instruction
// register and offers it to decode under an IR_valid/Decode_ready handshake.
// One PC_enable pulse is produced per captured word so the address generator
// advances. A Flush redirects fetching to the current PC. A memory that never
// acknowledges drives the unit into a sticky error state left only by reset.
//
// All outputs come straight from flops.
//
// Ports
//   Clock         in   system clock, all state updates on posedge
//   Reset_n       in   synchronous active-low reset
//   PC            in   current PC from the address generator
//   PC_enable     out  one-cycle pulse advancing the address generator
//   Mem_Req       out  read request to instruction memory
//   Mem_Addr      out  read address (low MEM_AW bits of the latched PC)
//   Mem_Ack       in   memory data valid, honoured only while Mem_Req=1
//   Mem_Data      in   instruction word, sampled when Mem_Ack=1
//   IR            out  instruction register
//   IR_PC         out  full address the IR was fetched from
//   IR_valid      out  IR holds an unconsumed instruction
//   Decode_ready  in   decode accepts the IR this cycle
//   Flush         in   discard in-flight fetch and held IR, refetch from PC
//   Fetch_Error   out  sticky memory-timeout flag
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | out of reset; latch PC and start the first request
//   S_ISSUE | Mem_Req high, waiting for Mem_Ack, timeout counter running
//   S_HOLD  | IR valid, waiting for decode to take it
//   S_FLUSH | one request-free cycle, latch the redirected PC
//   S_ERROR | memory timed out; parked until reset
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int MEM_AW  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] PC,
    output logic              PC_enable,
    output logic              Mem_Req,
    output logic [MEM_AW-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] IR_PC,
    output logic              IR_valid,
    input  logic              Decode_ready,
    input  logic              Flush,
    output logic              Fetch_Error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_HOLD  = 3'd2,
        S_FLUSH = 3'd3,
        S_ERROR = 3'd4
    } state_e;

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                mem_req_q,  mem_req_d;
    logic                pc_en_q,    pc_en_d;
    logic [DATA_W-1:0]   ir_q,       ir_d;
    logic [ADDR_W-1:0]   ir_pc_q,    ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
    logic                err_q,      err_d;

    // The last request cycle is the one in which the counter already shows
    // TIMEOUT-1 completed cycles; its closing edge makes TIMEOUT request cycles.
    logic                timeout_hit;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            pc_en_q    <= 1'b0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            pc_en_q    <= pc_en_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        pc_en_d    = 1'b0;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                addr_d    = PC;
                cnt_d     = '0;
                mem_req_d = 1'b1;
                state_d   = S_ISSUE;
            end

            S_ISSUE: begin
                if (Flush) begin
                    // Any same-cycle acknowledge is dropped on purpose.
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_FLUSH;
                end else if (Mem_Ack) begin
                    ir_d       = Mem_Data;
                    ir_pc_d    = addr_q;
                    ir_valid_d = 1'b1;
                    pc_en_d    = 1'b1;
                    mem_req_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_HOLD;
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    state_d   = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (Flush) begin
                    // Flush wins over a pending decode handshake.
                    ir_valid_d = 1'b0;
                    state_d    = S_FLUSH;
                end else if (Decode_ready && ir_valid_q) begin
                    // PC has already advanced from the capture-time pulse.
                    ir_valid_d = 1'b0;
                    addr_d     = PC;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    state_d    = S_ISSUE;
                end
            end

            S_FLUSH: begin
                addr_d    = PC;
                cnt_d     = '0;
                mem_req_d = 1'b1;
                state_d   = S_ISSUE;
            end

            S_ERROR: begin
                mem_req_d = 1'b0;
                err_d     = 1'b1;
            end

            default: begin
                mem_req_d  = 1'b0;
                ir_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    assign PC_enable   = pc_en_q;
    assign Mem_Req     = mem_req_q;
    assign Mem_Addr    = addr_q[MEM_AW-1:0];
    assign IR          = ir_q;
    assign IR_PC       = ir_pc_q;
    assign IR_valid    = ir_valid_q;
    assign Fetch_Error = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        Clock = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_enable;
    logic        mem_req;
    logic [6:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        decode_ready;
    logic        flush;
    logic        fetch_error;

    always #5 Clock = ~Clock;

    instruction_fetch_unit #(
        .ADDR_W(32), .MEM_AW(7), .DATA_W(32), .TIMEOUT(15)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (rst_n),
        .PC           (pc),
        .PC_enable    (pc_enable),
        .Mem_Req      (mem_req),
        .Mem_Addr     (mem_addr),
        .Mem_Ack      (mem_ack),
        .Mem_Data     (mem_data),
        .IR           (ir),
        .IR_PC        (ir_pc),
        .IR_valid     (ir_valid),
        .Decode_ready (decode_ready),
        .Flush        (flush),
        .Fetch_Error  (fetch_error)
    );

    int checks   = 0;
    int failures = 0;
    logic prev_pcen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behaves as the address generator: PC advances once per PC_enable pulse.
    task automatic tick();
        @(posedge Clock);
        #1;
        chk("pcen_not_consecutive", {63'd0, pc_enable & prev_pcen}, 64'd0);
        prev_pcen = pc_enable;
        if (pc_enable === 1'b1) pc = pc + 32'd1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pcen"},  {63'd0, pc_enable},   64'd0);
        chk({tag, "_req"},   {63'd0, mem_req},     64'd0);
        chk({tag, "_addr"},  {57'd0, mem_addr},    64'd0);
        chk({tag, "_ir"},    {32'd0, ir},          64'd0);
        chk({tag, "_irpc"},  {32'd0, ir_pc},       64'd0);
        chk({tag, "_valid"}, {63'd0, ir_valid},    64'd0);
        chk({tag, "_err"},   {63'd0, fetch_error}, 64'd0);
    endtask

    logic [31:0] mem [0:127];
    logic [31:0] slow_data;
    logic [31:0] exp_next;
    logic [6:0]  req_addr;
    logic        prev_req;
    int          delay;
    int          deliveries;

    initial begin
        rst_n = 1'b0; pc = 32'd0; mem_ack = 1'b0; mem_data = 32'd0;
        decode_ready = 1'b0; flush = 1'b0;

        // Reset held for two edges
        tick(); chk_zero("rst_a");
        tick(); chk_zero("rst_b");

        // Basic fetch from PC=5 with same-cycle acknowledge
        rst_n = 1'b1; pc = 32'h5;
        tick();
        chk("basic_req",   {63'd0, mem_req},  64'd1);
        chk("basic_addr",  {57'd0, mem_addr}, 64'h05);
        chk("basic_valid0",{63'd0, ir_valid}, 64'd0);
        mem_ack = 1'b1; mem_data = 32'hDEADBEEF;
        tick(); mem_ack = 1'b0;
        chk("basic_valid", {63'd0, ir_valid},  64'd1);
        chk("basic_ir",    {32'd0, ir},        64'hDEADBEEF);
        chk("basic_irpc",  {32'd0, ir_pc},     64'h5);
        chk("basic_pcen",  {63'd0, pc_enable}, 64'd1);
        chk("basic_req0",  {63'd0, mem_req},   64'd0);

        // Decode stall for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_ir",    {32'd0, ir},        64'hDEADBEEF);
            chk("stall_irpc",  {32'd0, ir_pc},     64'h5);
            chk("stall_valid", {63'd0, ir_valid},  64'd1);
            chk("stall_req",   {63'd0, mem_req},   64'd0);
            chk("stall_pcen",  {63'd0, pc_enable}, 64'd0);
        end
        decode_ready = 1'b1;
        tick(); decode_ready = 1'b0;
        chk("accept_valid", {63'd0, ir_valid}, 64'd0);
        chk("accept_req",   {63'd0, mem_req},  64'd1);
        chk("accept_addr",  {57'd0, mem_addr}, 64'h06);

        // Slow memory: ack after 4 waiting cycles
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("slow_req",   {63'd0, mem_req},  64'd1);
            chk("slow_addr",  {57'd0, mem_addr}, 64'h06);
            chk("slow_valid", {63'd0, ir_valid}, 64'd0);
            chk("slow_pcen",  {63'd0, pc_enable},64'd0);
        end
        slow_data = $urandom; mem_ack = 1'b1; mem_data = slow_data;
        tick(); mem_ack = 1'b0;
        chk("slow_ir",    {32'd0, ir},        {32'd0, slow_data});
        chk("slow_irpc",  {32'd0, ir_pc},     64'h6);
        chk("slow_cap",   {63'd0, ir_valid},  64'd1);
        chk("slow_pcen1", {63'd0, pc_enable}, 64'd1);
        tick();
        chk("slow_pcen2", {63'd0, pc_enable}, 64'd0);
        chk("slow_hold",  {63'd0, ir_valid},  64'd1);

        // Flush during ISSUE with a simultaneous acknowledge
        decode_ready = 1'b1;
        tick(); decode_ready = 1'b0;
        chk("fl_req",  {63'd0, mem_req},  64'd1);
        chk("fl_addr", {57'd0, mem_addr}, 64'h07);
        flush = 1'b1; mem_ack = 1'b1; mem_data = 32'h11111111; pc = 32'h40;
        tick(); flush = 1'b0; mem_ack = 1'b0;
        chk("fl_req0",  {63'd0, mem_req},   64'd0);
        chk("fl_valid", {63'd0, ir_valid},  64'd0);
        chk("fl_pcen",  {63'd0, pc_enable}, 64'd0);
        chk("fl_ir",    {32'd0, ir},        {32'd0, slow_data});
        tick();
        chk("fl_rereq",  {63'd0, mem_req},  64'd1);
        chk("fl_readdr", {57'd0, mem_addr}, 64'h40);
        mem_ack = 1'b1; mem_data = 32'hCAFEF00D;
        tick(); mem_ack = 1'b0;
        chk("fl_ir2",   {32'd0, ir},       64'hCAFEF00D);
        chk("fl_irpc2", {32'd0, ir_pc},    64'h40);
        chk("fl_valid2",{63'd0, ir_valid}, 64'd1);

        // Flush during HOLD beats Decode_ready; upper PC bits kept on IR_PC
        flush = 1'b1; decode_ready = 1'b1; pc = 32'h12345680;
        tick(); flush = 1'b0; decode_ready = 1'b0;
        chk("flh_valid", {63'd0, ir_valid},  64'd0);
        chk("flh_req",   {63'd0, mem_req},   64'd0);
        chk("flh_pcen",  {63'd0, pc_enable}, 64'd0);
        tick();
        chk("flh_rereq", {63'd0, mem_req},  64'd1);
        chk("flh_addr",  {57'd0, mem_addr}, 64'h00);
        mem_ack = 1'b1; mem_data = 32'h0BADC0DE;
        tick(); mem_ack = 1'b0;
        chk("flh_irpc", {32'd0, ir_pc}, 64'h12345680);
        chk("flh_ir",   {32'd0, ir},    64'h0BADC0DE);

        // Timeout: no acknowledge for 15 request cycles
        decode_ready = 1'b1;
        tick(); decode_ready = 1'b0;
        chk("to_req1",  {63'd0, mem_req},  64'd1);
        chk("to_addr",  {57'd0, mem_addr}, 64'h01);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("to_req", {63'd0, mem_req},     64'd1);
            chk("to_err", {63'd0, fetch_error}, 64'd0);
        end
        tick();
        chk("to_req_off", {63'd0, mem_req},     64'd0);
        chk("to_err_on",  {63'd0, fetch_error}, 64'd1);
        mem_ack = 1'b1; flush = 1'b1; mem_data = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_sticky", {63'd0, fetch_error}, 64'd1);
            chk("err_req",    {63'd0, mem_req},     64'd0);
            chk("err_pcen",   {63'd0, pc_enable},   64'd0);
            chk("err_valid",  {63'd0, ir_valid},    64'd0);
        end
        mem_ack = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        tick(); chk_zero("err_rst");

        // Restart after reset, fetching PC=0
        rst_n = 1'b1; pc = 32'h0;
        tick();
        chk("pc0_req",  {63'd0, mem_req},  64'd1);
        chk("pc0_addr", {57'd0, mem_addr}, 64'h00);
        mem_ack = 1'b1; mem_data = 32'h600DF00D;
        tick(); mem_ack = 1'b0;
        chk("pc0_valid", {63'd0, ir_valid}, 64'd1);
        chk("pc0_irpc",  {32'd0, ir_pc},    64'h0);
        chk("pc0_ir",    {32'd0, ir},       64'h600DF00D);

        // Reset during HOLD, then during ISSUE with an acknowledge present
        rst_n = 1'b0;
        tick(); chk_zero("rst_hold");
        rst_n = 1'b1;
        tick();
        chk("rst_reissue", {63'd0, mem_req},  64'd1);
        chk("rst_readdr",  {57'd0, mem_addr}, 64'h01);
        rst_n = 1'b0; mem_ack = 1'b1; mem_data = 32'h77777777;
        tick(); chk_zero("rst_issue");
        mem_ack = 1'b0;

        // Randomized traffic against a transaction-level model: deliveries
        // must follow consecutive PCs, restarting at the redirect target after
        // every flush, and carry the word stored at that address.
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        rst_n = 1'b1; pc = $urandom; exp_next = pc;
        prev_req = 1'b0; delay = 0; deliveries = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (mem_req) begin
                if (!prev_req) begin
                    delay    = $urandom_range(0, 5);
                    req_addr = mem_addr;
                    chk("rnd_req_addr", {57'd0, mem_addr}, {57'd0, exp_next[6:0]});
                end else begin
                    chk("rnd_addr_stable", {57'd0, mem_addr}, {57'd0, req_addr});
                end
                mem_ack = (delay == 0);
                if (delay != 0) delay--;
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
            end
            prev_req     = mem_req;
            mem_data     = mem[mem_addr];
            decode_ready = $urandom_range(0, 1) == 1;
            flush        = ($urandom_range(0, 15) == 0);
            if (ir_valid && decode_ready && !flush) begin
                chk("rnd_irpc", {32'd0, ir_pc}, {32'd0, exp_next});
                chk("rnd_ir",   {32'd0, ir},    {32'd0, mem[exp_next[6:0]]});
                exp_next = exp_next + 32'd1;
                deliveries++;
            end
            if (flush) begin
                pc       = $urandom;
                exp_next = pc;
            end
            tick();
            chk("rnd_no_err", {63'd0, fetch_error}, 64'd0);
        end
        chk("rnd_progress", {63'd0, deliveries >= 20}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
